traffic_sensor_cond: RTL and testbench
======================================

Name: traffic_sensor_cond

Overview:
- Conditions the raw vehicle-loop detector inputs for roads A and B into the clean presence levels `ta`/`tb` consumed directly by the traffic light controller.
- Sits immediately upstream of the controller.
- Per road: synchronizes, debounces and applies gap-extension hold to the detector input, and counts vehicle arrivals for a maintenance readout.

Parameters:
- DEB_TICKS, 3, consecutive ticks a synchronized input must differ from the filtered state before the filtered state flips (>=1).
- HOLD_TICKS, 4, ticks the presence output is held after the filtered input falls (0 = no hold).
- CNT_W, 8, width of each vehicle arrival counter.
- STUCK_TICKS, 64, ticks of continuous filtered presence before a stuck fault (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle timebase enable; all tick counts advance only on cycles with tick=1
- raw_a  in  1  asynchronous loop detector, road A, active-high
- raw_b  in  1  asynchronous loop detector, road B, active-high
- cnt_clr  in  1  synchronous clear of both arrival counters
- ta  out  1  conditioned presence, road A (to controller Ta)
- tb  out  1  conditioned presence, road B (to controller Tb)
- count_a  out  CNT_W  vehicle arrivals, road A, saturating
- count_b  out  CNT_W  vehicle arrivals, road B, saturating
- fault_a  out  1  stuck-detector flag, road A
- fault_b  out  1  stuck-detector flag, road B

Behaviour:
- Reset: all synchronizer flops, filtered states, debounce/hold/stuck counters are 0. ta, tb, count_a, count_b, fault_a and fault_b are all 0.
- Both channels are identical and independent.
- Synchronizer: 2-flop chain on raw_x gives sync_x, 2 clocks latency.
- Debounce:
  - Any cycle with sync==filt clears deb_cnt to 0 immediately, tick or not.
  - On a tick with sync!=filt: if deb_cnt==DEB_TICKS-1, then filt<=sync and deb_cnt<=0; else deb_cnt++.
  - Result: filt flips on the DEB_TICKS-th consecutive differing tick. A single differing tick followed by agreement is rejected.
- Hold:
  - On the clock where filt falls 1->0, hold_cnt<=HOLD_TICKS.
  - On each tick while hold_cnt!=0 and filt==0, hold_cnt--.
  - When filt rises, hold_cnt<=0.
- Presence output:
  - t is registered: t <= filt_next | (hold_cnt_next!=0).
  - t rises 1 clock after filt rises.
  - Through a fall, t stays continuously high while hold is nonzero.
  - t drops 1 clock after hold_cnt reaches 0, or 1 clock after filt falls if HOLD_TICKS=0.
  - A re-rise of filt during hold keeps t high with no glitch.
- Arrival counter:
  - Increments by 1 on the clock filt rises.
  - Saturates at 2^CNT_W-1.
  - cnt_clr sets both counters to 0 and has priority over a simultaneous increment (that arrival is lost).
- Reset mid-operation: everything returns to reset values asynchronously. No partial debounce or hold state survives.
- tick held high every cycle is legal: counts then advance per clock.

Optional Feature:
- Macro: TRAFFIC_SENSOR_STUCK_DETECT_EN.
- Defined:
  - Per channel, stuck_cnt increments on each tick with filt=1 and clears when filt=0.
  - When it reaches STUCK_TICKS, fault_x is set. fault_x stays 1 until filt falls or reset.
  - While fault_x=1, t_x is forced 0 so the controller is not locked to a dead loop. Hold is not applied on the fall that clears the fault.
  - The counter is unaffected by faults.
- Not defined: no stuck logic; fault_a/fault_b are tied 0 and the ports remain present.

Decomposition:
- Package traffic_sensor_pkg: default DEB_TICKS/HOLD_TICKS/STUCK_TICKS/CNT_W constants and a $clog2-derived counter-width helper.
- One sub-module, sensor_channel: synchronizer, debounce, hold, counter and stuck logic for one road. It is instantiated twice (A, B). The top contains only the instances and port wiring.

Test Plan:
All scenarios use DEB_TICKS=3, HOLD_TICKS=4, CNT_W=4 and tick every 4th clock unless stated.
- Reset:
  - Stimulus: assert reset with raw_a=raw_b=1.
  - Required: ta=tb=0, counts 0, faults 0. After release, ta rises on the 3rd tick after sync_a=1 (+1 clock) and count_a=1.
- Glitch rejection:
  - Stimulus: raw_a high for 2 ticks, then low.
  - Required: ta never asserts, count_a stays 0.
- Hold:
  - Stimulus: raw_a high 10 ticks, then low.
  - Required: ta stays high through the debounced fall plus 4 ticks, then drops 1 clock after hold_cnt=0.
  - Stimulus: re-raise raw_a during the hold.
  - Required: ta never drops.
- Counter:
  - Stimulus: 17 clean arrivals on raw_b.
  - Required: count_b saturates at 15.
  - Stimulus: cnt_clr in the same clock as a filt rise.
  - Required: count_b=0.
- Independence:
  - Stimulus: raw_a and raw_b toggled with different patterns simultaneously.
  - Required: ta/tb and count_a/count_b each match their single-channel expectation.
- Stuck (macro defined, STUCK_TICKS=8):
  - Stimulus: raw_a held high.
  - Required: fault_a=1 and ta=0 after the 8th tick of presence.
  - Stimulus: release raw_a.
  - Required: fault_a clears when filt falls, with no hold.

Source files
------------

// File: rtl/traffic_sensor_pkg.sv
// Shared defaults and sizing helper for the traffic sensor conditioner.
package traffic_sensor_pkg;

  localparam int DEF_DEB_TICKS   = 3;
  localparam int DEF_HOLD_TICKS  = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_STUCK_TICKS = 64;

  // Bits needed for a counter that must hold values 0..max_val (at least 1).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One road's detector conditioning: 2-flop synchronizer, tick-based debounce,
// gap-extension hold, saturating arrival counter and (with
// TRAFFIC_SENSOR_STUCK_DETECT_EN) a stuck-loop detector that masks presence.
module sensor_channel
  import traffic_sensor_pkg::*;
#(
  parameter int DEB_TICKS   = DEF_DEB_TICKS,
  parameter int HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int CNT_W       = DEF_CNT_W
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
  , parameter int STUCK_TICKS = DEF_STUCK_TICKS
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             raw,
  input  logic             cnt_clr,
  output logic             t,
  output logic [CNT_W-1:0] count,
  output logic             fault
);

  localparam int DW = cnt_width(DEB_TICKS - 1);
  localparam int HW = cnt_width(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          t_q, t_d;
  logic          filt_rise, filt_fall;
  logic          fault_d;
  logic          fault_drop;

  // Synchronizer chain inputs and debounce: flip filt on the DEB_TICKS-th differing tick.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    deb_d   = deb_q;
    if (sync2_q == filt_q) begin
      deb_d = {DW{1'b0}};
    end else if (tick) begin
      if (deb_q == DW'(DEB_TICKS - 1)) begin
        filt_d = sync2_q;
        deb_d  = {DW{1'b0}};
      end else begin
        deb_d = deb_q + DW'(1);
      end
    end else begin
      deb_d = deb_q;
    end
    filt_rise = filt_d & ~filt_q;
    filt_fall = ~filt_d & filt_q;
  end

`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
  localparam int SW = cnt_width(STUCK_TICKS);
  logic [SW-1:0] stuck_q, stuck_d;
  logic          fault_q;

  // Count ticks of continuous presence; latch a fault until filt falls.
  always_comb begin
    stuck_d = stuck_q;
    if (!filt_q) begin
      stuck_d = {SW{1'b0}};
    end else if (tick && (stuck_q != SW'(STUCK_TICKS))) begin
      stuck_d = stuck_q + SW'(1);
    end else begin
      stuck_d = stuck_q;
    end
    fault_d    = filt_d & (fault_q | (stuck_d == SW'(STUCK_TICKS)));
    fault_drop = fault_q & filt_fall;
  end

  // Stuck detector state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stuck_q <= {SW{1'b0}};
      fault_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault_d    = 1'b0;
  assign fault_drop = 1'b0;
  assign fault      = 1'b0;
`endif

  // Gap-extension hold and registered presence; a fault-clearing fall gets no hold.
  always_comb begin
    hold_d = hold_q;
    if (filt_rise) begin
      hold_d = {HW{1'b0}};
    end else if (filt_fall) begin
      if (fault_drop) begin
        hold_d = {HW{1'b0}};
      end else begin
        hold_d = HW'(HOLD_TICKS);
      end
    end else if (tick && (hold_q != {HW{1'b0}}) && !filt_q) begin
      hold_d = hold_q - HW'(1);
    end else begin
      hold_d = hold_q;
    end
    t_d = (filt_d | (hold_d != {HW{1'b0}})) & ~fault_d;
  end

  // Saturating arrival counter; clear wins over a same-cycle arrival.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (filt_rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      deb_q   <= {DW{1'b0}};
      hold_q  <= {HW{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      t_q     <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
    end
  end

  assign t     = t_q;
  assign count = cnt_q;

endmodule

// File: rtl/traffic_sensor_cond.sv
// Loop detector conditioning for roads A and B feeding the light controller.
// Optional stuck-loop detection: define TRAFFIC_SENSOR_STUCK_DETECT_EN.
module traffic_sensor_cond
  import traffic_sensor_pkg::*;
#(
  parameter int DEB_TICKS   = DEF_DEB_TICKS,
  parameter int HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int CNT_W       = DEF_CNT_W
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
  , parameter int STUCK_TICKS = DEF_STUCK_TICKS
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic             cnt_clr,
  output logic             ta,
  output logic             tb,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             fault_a,
  output logic             fault_b
);

  sensor_channel #(
    .DEB_TICKS  (DEB_TICKS),
    .HOLD_TICKS (HOLD_TICKS),
    .CNT_W      (CNT_W)
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
    , .STUCK_TICKS(STUCK_TICKS)
`endif
  ) u_chan_a (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .raw     (raw_a),
    .cnt_clr (cnt_clr),
    .t       (ta),
    .count   (count_a),
    .fault   (fault_a)
  );

  sensor_channel #(
    .DEB_TICKS  (DEB_TICKS),
    .HOLD_TICKS (HOLD_TICKS),
    .CNT_W      (CNT_W)
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
    , .STUCK_TICKS(STUCK_TICKS)
`endif
  ) u_chan_b (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .raw     (raw_b),
    .cnt_clr (cnt_clr),
    .t       (tb),
    .count   (count_b),
    .fault   (fault_b)
  );

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Directed bench for traffic_sensor_cond: a per-cycle reference model feeds a
// scoreboard queue, plus directed end-of-scenario checks.
module tb_traffic_sensor_cond;

  localparam int DEB   = 3;
  localparam int HOLD  = 4;
  localparam int STUCK = 8;
  localparam int CMAX  = 15;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       raw_a;
  logic       raw_b;
  logic       cnt_clr;
  logic       ta;
  logic       tb;
  logic [3:0] count_a;
  logic [3:0] count_b;
  logic       fault_a;
  logic       fault_b;

  traffic_sensor_cond #(
    .DEB_TICKS  (DEB),
    .HOLD_TICKS (HOLD),
    .CNT_W      (4)
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
    , .STUCK_TICKS(STUCK)
`endif
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .cnt_clr (cnt_clr),
    .ta      (ta),
    .tb      (tb),
    .count_a (count_a),
    .count_b (count_b),
    .fault_a (fault_a),
    .fault_b (fault_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  logic seen_ta;
  logic ta_dropped;
  logic [11:0] sb_q[$];

  // reference model state, index 0 = road A, 1 = road B
  int m_s1[2], m_s2[2], m_filt[2], m_deb[2], m_hold[2];
  int m_cnt[2], m_t[2], m_stuck[2], m_fault[2];

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_filt[c] = 0; m_deb[c] = 0; m_hold[c] = 0;
      m_cnt[c] = 0; m_t[c] = 0; m_stuck[c] = 0; m_fault[c] = 0;
    end
  endtask

  // One clock of the behavioural channel description.
  task automatic model_step(input int c, input logic r, input logic tk, input logic clr);
    int nf, nd, nh, ns, nfa;
    bit rose, fell;
    nf = m_filt[c];
    nd = m_deb[c];
    if (m_s2[c] == m_filt[c]) nd = 0;
    else if (tk) begin
      if (m_deb[c] + 1 >= DEB) begin nf = m_s2[c]; nd = 0; end
      else nd = m_deb[c] + 1;
    end
    rose = (nf == 1) && (m_filt[c] == 0);
    fell = (nf == 0) && (m_filt[c] == 1);
    ns = 0; nfa = 0;
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
    if (m_filt[c] == 1) ns = (tk && m_stuck[c] < STUCK) ? m_stuck[c] + 1 : m_stuck[c];
    nfa = (nf == 1 && (m_fault[c] == 1 || ns >= STUCK)) ? 1 : 0;
`endif
    nh = m_hold[c];
    if (rose) nh = 0;
    else if (fell) nh = (m_fault[c] == 1) ? 0 : HOLD;
    else if (tk && m_hold[c] > 0 && m_filt[c] == 0) nh = m_hold[c] - 1;
    if (clr) m_cnt[c] = 0;
    else if (rose && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
    m_t[c]     = ((nf == 1 || nh > 0) && nfa == 0) ? 1 : 0;
    m_filt[c]  = nf;
    m_deb[c]   = nd;
    m_hold[c]  = nh;
    m_stuck[c] = ns;
    m_fault[c] = nfa;
    m_s2[c]    = m_s1[c];
    m_s1[c]    = r ? 1 : 0;
  endtask

  function automatic logic [11:0] model_vec();
    logic [3:0] ca, cb;
    ca = 4'(m_cnt[0]);
    cb = 4'(m_cnt[1]);
    return {m_t[0] != 0, m_t[1] != 0, m_fault[0] != 0, m_fault[1] != 0, ca, cb};
  endfunction

  // Drive one clock of stimulus, push the model prediction, then pop and compare.
  task automatic drive_cycle(input logic ra, input logic rb, input logic clr);
    logic [11:0] e;
    tick    = (cyc % 4 == 3) ? 1'b1 : 1'b0;
    raw_a   = ra;
    raw_b   = rb;
    cnt_clr = clr;
    model_step(0, ra, tick, clr);
    model_step(1, rb, tick, clr);
    sb_q.push_back(model_vec());
    @(posedge clock);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check("cycle", {ta, tb, fault_a, fault_b, count_a, count_b}, e);
    if (ta) seen_ta = 1'b1;
  endtask

  task automatic run(input logic ra, input logic rb, input int n);
    for (int i = 0; i < n; i++) drive_cycle(ra, rb, 1'b0);
  endtask

  task automatic align();
    while (cyc % 4 != 0) drive_cycle(raw_a, raw_b, 1'b0);
  endtask

  task automatic apply_reset(input logic ra, input logic rb, input int n);
    reset   = 1'b1;
    raw_a   = ra;
    raw_b   = rb;
    tick    = 1'b0;
    cnt_clr = 1'b0;
    #2;
    check("reset_async", {ta, tb, fault_a, fault_b, count_a, count_b}, 12'd0);
    repeat (n) @(posedge clock);
    #1;
    check("reset_hold", {ta, tb, fault_a, fault_b, count_a, count_b}, 12'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; raw_a = 1'b0; raw_b = 1'b0; cnt_clr = 1'b0;
    seen_ta = 1'b0; ta_dropped = 1'b0;
    model_reset();
    #1;
    // reset with both detectors active, then release
    apply_reset(1'b1, 1'b1, 3);
    run(1'b1, 1'b1, 20);
    check("reset_release_ta", 12'(ta), 12'd1);
    check("reset_release_cnt_a", 12'(count_a), 12'd1);
    run(1'b0, 1'b0, 40);
    check("idle_ta_tb", {10'd0, ta, tb}, 12'd0);

    // glitch: two ticks of presence must be rejected
    align();
    seen_ta = 1'b0;
    run(1'b1, 1'b0, 8);
    run(1'b0, 1'b0, 20);
    check("glitch_ta", 12'(seen_ta), 12'd0);
    check("glitch_cnt_a", 12'(count_a), 12'd1);

    // hold through a fall, re-raise during hold, then final fall
    align();
    ta_dropped = 1'b0;
    for (int j = 0; j < 116; j++) begin
      drive_cycle((j < 40) || (j >= 52 && j < 76), 1'b0, 1'b0);
      if (j >= 12 && j <= 100 && !ta) ta_dropped = 1'b1;
    end
    check("hold_no_drop", 12'(ta_dropped), 12'd0);
    check("hold_final_ta", 12'(ta), 12'd0);
    check("hold_cnt_a", 12'(count_a), 12'd3);

    // counter saturation on road B
    for (int k = 0; k < 17; k++) begin
      run(1'b0, 1'b1, 16);
      run(1'b0, 1'b0, 16);
    end
    check("sat_cnt_b", 12'(count_b), 12'd15);

    // clear coinciding with a filt rise on road B
    align();
    run(1'b0, 1'b1, 11);
    drive_cycle(1'b0, 1'b1, 1'b1);
    check("clr_cnt_b", 12'(count_b), 12'd0);
    check("clr_cnt_a", 12'(count_a), 12'd0);
    run(1'b0, 1'b1, 4);
    check("clr_lost_arrival", 12'(count_b), 12'd0);

    // independent simultaneous patterns
    for (int j = 0; j < 200; j++)
      drive_cycle(((j / 24) % 2) == 1, (((j + 5) / 40) % 2) == 1, 1'b0);
    check("indep_cnt_a", 12'(count_a), 12'd4);
    check("indep_cnt_b", 12'(count_b), 12'd2);

    // reset in the middle of a hold interval
    align();
    run(1'b1, 1'b0, 14);
    run(1'b0, 1'b0, 16);
    check("pre_reset_hold_ta", 12'(ta), 12'd1);
    apply_reset(1'b0, 1'b0, 2);
    run(1'b0, 1'b0, 30);
    check("post_reset_ta", 12'(ta), 12'd0);
    check("post_reset_cnt_a", 12'(count_a), 12'd0);

`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
    // stuck detector on road A
    align();
    run(1'b1, 1'b0, 60);
    check("stuck_fault_a", 12'(fault_a), 12'd1);
    check("stuck_ta_masked", 12'(ta), 12'd0);
    check("stuck_cnt_a", 12'(count_a), 12'd1);
    seen_ta = 1'b0;
    run(1'b0, 1'b0, 40);
    check("stuck_clear_fault", 12'(fault_a), 12'd0);
    check("stuck_no_hold", 12'(seen_ta), 12'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
